// File: rtl/starship_rom_arbiter_pkg.sv
// Shared types and defaults for the two-port ROM read arbiter.
package starship_rom_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    typedef logic port_id_t;

endpackage

// File: rtl/starship_rr_arb2.sv
// Two-way round-robin grant; the pointer flips to the other port after any acceptance.
module starship_rr_arb2
    import starship_rom_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant,
    output port_id_t   grant_id
);

    port_id_t ptr_q, ptr_d;

    always_comb begin
        grant_id = ptr_q;
        // Preferred port idle: fall through to the other one.
        if (!req[ptr_q]) begin
            grant_id = ~ptr_q;
        end
        grant = '0;
        if (en && req[grant_id]) begin
            grant[grant_id] = 1'b1;
        end
        ptr_d = ptr_q;
        if (|grant) begin
            ptr_d = ~grant_id;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/starship_rom_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous ROM macro.
// Define STARSHIP_ROM_ARB_PERF_EN to enable saturating per-port grant counters.
module starship_rom_arbiter
    import starship_rom_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [ADDR_W-1:0] req_addr_1,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              rom_me,
    output logic              rom_oe,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic [31:0]       grant_cnt_0,
    output logic [31:0]       grant_cnt_1
);

    state_e   state_q, state_d;
    port_id_t owner_q, owner_d;
    logic     arb_en;
    logic     accept;
    logic [1:0] grant;
    port_id_t grant_id;

    // New reads only when nothing is pending or the pending one retires this cycle.
    assign arb_en = !reset && ((state_q == IDLE) || resp_ready[owner_q]);
    assign accept = |grant;

    starship_rr_arb2 u_arb (
        .clock    (clock),
        .reset    (reset),
        .req      (req_valid),
        .en       (arb_en),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready   = grant;
    assign rom_me      = accept;
    assign rom_address = grant_id ? req_addr_1 : req_addr_0;
    assign resp_data   = rom_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        resp_valid = '0;
        rom_oe     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PEND;
                    owner_d = grant_id;
                end
            end
            PEND: begin
                rom_oe              = 1'b1;
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    if (accept) begin
                        owner_d = grant_id;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

`ifdef STARSHIP_ROM_ARB_PERF_EN
    logic [31:0] cnt0_q, cnt0_d;
    logic [31:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (grant[0] && (cnt0_q != '1)) begin
            cnt0_d = cnt0_q + 32'd1;
        end
        if (grant[1] && (cnt1_q != '1)) begin
            cnt1_d = cnt1_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt_0 = cnt0_q;
    assign grant_cnt_1 = cnt1_q;
`else
    assign grant_cnt_0 = '0;
    assign grant_cnt_1 = '0;
`endif

endmodule
